iq_window_integrator: RTL
=========================

Name: iq_window_integrator

Overview:
- Demodulation front-end stage directly upstream of the analysis FSM. Produces one integrated (I, Q) point per trigger.
- Consumes the 5-sample-per-cycle I stream (channel 0) and Q stream (channel 1).
- After a configurable delay, sums all samples over a configurable window, scales the sums and saturates them.
- Emits i_val/q_val with a single-cycle iq_valid strobe for the histogram/classification logic.

Parameters:
- DATA_W, 16, width of each input sample (signed).
- OUT_W, 32, width of i_val/q_val (signed).
- ACC_W, 40, internal accumulator width (signed).
- LEN_W, 16, width of the delay and window counters.

Ports:
- clk100  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- trigger  in  1  acquisition trigger, level input; the rising edge starts an acquisition.
- data0_in_0..data0_in_4  in  16 each  signed I samples; _0 is the oldest sample.
- data1_in_0..data1_in_4  in  16 each  signed Q samples.
- data_valid_in  in  1  sample words valid this cycle.
- start_delay  in  16  number of valid cycles to skip after the trigger.
- window_len  in  16  number of valid cycles to integrate; 0 is treated as 1.
- out_shift  in  4  arithmetic right shift applied to the sums.
- busy  out  1  high whenever state != IDLE.
- iq_valid  out  1  one-cycle result strobe.
- i_val  out  32  signed I result, held until the next result.
- q_val  out  32  signed Q result, held until the next result.
- overflow  out  1  saturation flag for the current result, updated with iq_valid.
- missed_trigger  out  1  one-cycle pulse when a trigger edge is ignored.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; accumulators, counters, i_val, q_val, iq_valid, overflow, missed_trigger and busy all go to 0.
  - trig_d is set to 1, so a trigger held high through reset does not start an acquisition.
  - Asserting reset mid-acquisition aborts it with no iq_valid.
- Edge detect: trig_edge = trigger & ~trig_d; trig_d is a register.
- IDLE:
  - On trig_edge, latch start_delay, window_len (0 becomes 1) and out_shift into shadow registers.
  - Clear both accumulators and counters.
  - Go to DELAY if the latched delay > 0, else INTEG.
- DELAY:
  - The counter increments only on data_valid_in cycles.
  - When the counter reaches the latched delay on a valid cycle, go to INTEG.
  - That valid cycle is not integrated.
- INTEG:
  - On each data_valid_in cycle, acc_i += sext(d0_0+d0_1+d0_2+d0_3+d0_4).
  - The 5-sample sum uses 19-bit signed arithmetic, then is sign-extended to ACC_W. Q is handled identically with data1.
  - Cycles with data_valid_in=0 are ignored; they neither count nor accumulate.
  - When the valid count reaches the latched window, go to DONE on the cycle after the last accepted word.
- DONE (exactly one cycle):
  - r = acc >>> out_shift (arithmetic shift).
  - If r > 2^31-1, output 2^31-1; if r < -2^31, output -2^31. overflow=1 if either channel saturated, else 0.
  - Register i_val, q_val and overflow; iq_valid=1 for this cycle; return to IDLE.
- Latency: iq_valid is high one cycle after the last valid integrated word (registered outputs).
- Retrigger: a trig_edge while state != IDLE (including DONE) is ignored and missed_trigger pulses for 1 cycle. The edge detector still updates trig_d.
- Config changes: changes to config inputs during an acquisition have no effect until the next trigger.
- Accumulator width: 40 bits cannot overflow. The maximum is 5*32768*65535 < 2^39.

Test Plan:
- Basic integration:
  - Stimulus: I samples all 100, Q all -50, delay=0, window=4, shift=0, data_valid_in held high, trigger 0->1.
  - Required: busy=1 the cycle after the edge; iq_valid exactly once; i_val=2000, q_val=-1000, overflow=0.
- Delay with valid gaps:
  - Stimulus: delay=3, window=2, I word k = all k (k=1,2,...), data_valid_in toggling 1,0,1,0.
  - Required: words 1-3 skipped, words 4 and 5 summed, so i_val=5*(4+5)=45.
  - Required: iq_valid one cycle after word 5 is accepted.
- Saturation and shift:
  - Stimulus: I=32767 on all lanes, window=65535, shift=0.
  - Required: i_val=2147483647, overflow=1.
  - Stimulus: same with shift=4.
  - Required: i_val=671057920, overflow=0.
- Window zero / negative shift:
  - Stimulus: window=0, I lanes -3,-3,-3,-3,-2 (sum -14), shift=2.
  - Required: exactly one word integrated; i_val=-4 (arithmetic floor).
- Retrigger and trigger across reset:
  - Stimulus: second trigger edge during INTEG.
  - Required: missed_trigger pulses once; first result unaffected; no second iq_valid.
  - Stimulus: trigger held high through reset release.
  - Required: no acquisition starts.
- Mid-operation reset:
  - Stimulus: reset_n=0 for 1 cycle halfway through window=8.
  - Required: busy=0, i_val=0, no iq_valid.
  - Stimulus: new trigger afterwards.
  - Required: a correct fresh result.

Source files
------------

// File: rtl/iq_window_integrator_if.sv
// Sample/result bus of the IQ window integrator: five-lane I and Q sample words
// in, one integrated (I, Q) point with its saturation flag out.
interface iq_window_integrator_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic signed [DATA_W-1:0] data0_in_0;
  logic signed [DATA_W-1:0] data0_in_1;
  logic signed [DATA_W-1:0] data0_in_2;
  logic signed [DATA_W-1:0] data0_in_3;
  logic signed [DATA_W-1:0] data0_in_4;
  logic signed [DATA_W-1:0] data1_in_0;
  logic signed [DATA_W-1:0] data1_in_1;
  logic signed [DATA_W-1:0] data1_in_2;
  logic signed [DATA_W-1:0] data1_in_3;
  logic signed [DATA_W-1:0] data1_in_4;
  logic                     data_valid_in;
  logic                     iq_valid;
  logic signed [OUT_W-1:0]  i_val;
  logic signed [OUT_W-1:0]  q_val;
  logic                     overflow;

  modport master (
    output data0_in_0, data0_in_1, data0_in_2, data0_in_3, data0_in_4,
    output data1_in_0, data1_in_1, data1_in_2, data1_in_3, data1_in_4,
    output data_valid_in,
    input  iq_valid, i_val, q_val, overflow
  );

  modport slave (
    input  data0_in_0, data0_in_1, data0_in_2, data0_in_3, data0_in_4,
    input  data1_in_0, data1_in_1, data1_in_2, data1_in_3, data1_in_4,
    input  data_valid_in,
    output iq_valid, i_val, q_val, overflow
  );
endinterface

// File: rtl/iq_window_integrator.sv
// Trigger-started IQ integrator: skips start_delay valid words, sums window_len
// valid words per channel, then shifts, saturates and strobes one (I, Q) result.
module iq_window_integrator #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 16
) (
  input  logic                   clk100,
  input  logic                   reset_n,
  input  logic                   trigger,
  iq_window_integrator_if.slave  bus,
  input  logic [LEN_W-1:0]       start_delay,
  input  logic [LEN_W-1:0]       window_len,
  input  logic [3:0]             out_shift,
  output logic                   busy,
  output logic                   missed_trigger
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_INTEG = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [LEN_W-1:0]        LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  // Five-lane sum in DATA_W+3 bits (cannot overflow), then sign-extended to ACC_W.
  function automatic logic signed [ACC_W-1:0] sum5(
    input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e);
    logic [DATA_W+2:0] s;
    s = {{3{a[DATA_W-1]}}, a} + {{3{b[DATA_W-1]}}, b} + {{3{c[DATA_W-1]}}, c}
      + {{3{d[DATA_W-1]}}, d} + {{3{e[DATA_W-1]}}, e};
    return {{(ACC_W-DATA_W-3){s[DATA_W+2]}}, s};
  endfunction

  // Returns {saturated, value}: arithmetic shift then clamp to the OUT_W range.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [ACC_W-1:0] acc,
                                               input logic [3:0] sh);
    logic signed [ACC_W-1:0] r;
    r = acc >>> sh;
    if (r > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (r < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      return {1'b0, r[OUT_W-1:0]};
    end
  endfunction

  state_e                   state_q, state_d;
  logic                     trig_d_q, trig_d_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d, delay_q, delay_d, win_q, win_d;
  logic [3:0]               shift_q, shift_d;
  logic signed [OUT_W-1:0]  i_val_q, i_val_d, q_val_q, q_val_d;
  logic                     ovf_q, ovf_d, iq_valid_q, iq_valid_d;
  logic                     missed_q, missed_d, busy_q, busy_d;
  logic                     trig_edge;
  logic signed [ACC_W-1:0]  acc_i_nx, acc_q_nx;
  logic [OUT_W:0]           res_i, res_q;

  // Next-state, counters, accumulators and result computation.
  always_comb begin
    state_d    = state_q;
    trig_d_d   = trigger;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    cnt_d      = cnt_q;
    delay_d    = delay_q;
    win_d      = win_q;
    shift_d    = shift_q;
    i_val_d    = i_val_q;
    q_val_d    = q_val_q;
    ovf_d      = ovf_q;
    iq_valid_d = 1'b0;
    missed_d   = 1'b0;
    trig_edge  = trigger & ~trig_d_q;
    acc_i_nx   = acc_i_q + sum5(bus.data0_in_0, bus.data0_in_1, bus.data0_in_2,
                                bus.data0_in_3, bus.data0_in_4);
    acc_q_nx   = acc_q_q + sum5(bus.data1_in_0, bus.data1_in_1, bus.data1_in_2,
                                bus.data1_in_3, bus.data1_in_4);
    // The result is taken from the post-update sum so it is ready in the DONE cycle.
    res_i      = scale_sat(acc_i_nx, shift_q);
    res_q      = scale_sat(acc_q_nx, shift_q);

    case (state_q)
      ST_IDLE: begin
        if (trig_edge) begin
          delay_d = start_delay;
          win_d   = (window_len == {LEN_W{1'b0}}) ? LEN_ONE : window_len;
          shift_d = out_shift;
          acc_i_d = {ACC_W{1'b0}};
          acc_q_d = {ACC_W{1'b0}};
          cnt_d   = {LEN_W{1'b0}};
          state_d = (start_delay != {LEN_W{1'b0}}) ? ST_DELAY : ST_INTEG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (bus.data_valid_in) begin
          if ((cnt_q + LEN_ONE) == delay_q) begin
            cnt_d   = {LEN_W{1'b0}};
            state_d = ST_INTEG;
          end else begin
            cnt_d = cnt_q + LEN_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_INTEG: begin
        if (bus.data_valid_in) begin
          acc_i_d = acc_i_nx;
          acc_q_d = acc_q_nx;
          if ((cnt_q + LEN_ONE) == win_q) begin
            cnt_d      = {LEN_W{1'b0}};
            state_d    = ST_DONE;
            i_val_d    = res_i[OUT_W-1:0];
            q_val_d    = res_q[OUT_W-1:0];
            ovf_d      = res_i[OUT_W] | res_q[OUT_W];
            iq_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + LEN_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (trig_edge && (state_q != ST_IDLE)) begin
      missed_d = 1'b1;
    end else begin
      missed_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset arms trig_d so a held trigger is not an edge.
  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      trig_d_q   <= 1'b1;
      acc_i_q    <= {ACC_W{1'b0}};
      acc_q_q    <= {ACC_W{1'b0}};
      cnt_q      <= {LEN_W{1'b0}};
      delay_q    <= {LEN_W{1'b0}};
      win_q      <= {LEN_W{1'b0}};
      shift_q    <= 4'd0;
      i_val_q    <= {OUT_W{1'b0}};
      q_val_q    <= {OUT_W{1'b0}};
      ovf_q      <= 1'b0;
      iq_valid_q <= 1'b0;
      missed_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_d_q   <= trig_d_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      cnt_q      <= cnt_d;
      delay_q    <= delay_d;
      win_q      <= win_d;
      shift_q    <= shift_d;
      i_val_q    <= i_val_d;
      q_val_q    <= q_val_d;
      ovf_q      <= ovf_d;
      iq_valid_q <= iq_valid_d;
      missed_q   <= missed_d;
      busy_q     <= busy_d;
    end
  end

  assign busy           = busy_q;
  assign missed_trigger = missed_q;
  assign bus.iq_valid   = iq_valid_q;
  assign bus.i_val      = i_val_q;
  assign bus.q_val      = q_val_q;
  assign bus.overflow   = ovf_q;

endmodule
